// File: rtl/bram_stream_reader_pkg.sv
// rtl/bram_stream_reader_pkg.sv - shared state type and default sizes for the BRAM stream reader
package bram_reader_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam int DATA_W_DEF     = 8;
    localparam int ADDR_W_DEF     = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    // RAM output register plus the capture stage
    localparam int INFLIGHT_MAX   = 2;
    localparam int INFLIGHT_W     = $clog2(INFLIGHT_MAX + 1);
endpackage

// File: rtl/bram_stream_reader_if.sv
// rtl/bram_stream_reader_if.sv - valid/ready output stream with end-of-command marker
interface bram_stream_reader_if
    import bram_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/bram_stream_reader_stream_fifo.sv
// rtl/bram_stream_reader_stream_fifo.sv - synchronous FIFO with first-word-fall-through head
module stream_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - streams a contiguous BRAM window out over valid/ready
// Define BRAM_READER_CHECKSUM_EN to add the per-command checksum output.
module bram_stream_reader
    import bram_reader_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      len,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata,
`ifdef BRAM_READER_CHECKSUM_EN
    output logic [DATA_W-1:0]    checksum,
`endif
    bram_stream_reader_if.master m
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    state_e                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W:0]       remaining_q;
    logic [INFLIGHT_W-1:0] inflight_q;
    logic [INFLIGHT_W-1:0] inflight_d;
    logic                  capture_q;
    logic                  capture_last_q;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      occupancy;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_W:0]       fifo_head;
    logic                  credit_ok;
    logic                  issue;
    logic                  last_issue;
    logic                  beat;

    // Reads in flight already own a FIFO slot, so the buffer can never overflow.
    assign occupancy  = fifo_count + CNT_W'(inflight_q);
    assign credit_ok  = !fifo_full && (occupancy < DEPTH_CNT);
    assign issue      = (state_q == RUN) && (remaining_q != '0) && credit_ok;
    assign last_issue = issue && (remaining_q == (ADDR_W + 1)'(1));
    assign beat       = m.m_valid && m.m_ready;

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !capture_q)      inflight_d = inflight_q + INFLIGHT_W'(1);
        else if (!issue && capture_q) inflight_d = inflight_q - INFLIGHT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            inflight_q     <= '0;
            capture_q      <= 1'b0;
            capture_last_q <= 1'b0;
        end else begin
            inflight_q     <= inflight_d;
            capture_q      <= issue;
            capture_last_q <= last_issue;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            addr_q      <= base_addr;
                            remaining_q <= len;
                            state_q     <= RUN;
                        end else begin
                            state_q     <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - (ADDR_W + 1)'(1);
                        if (last_issue) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // the tagged last beat leaving implies FIFO and pipeline are empty
                    if (beat && m.m_last) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture_q),
        .push_data ({capture_last_q, mem_rdata}),
        .pop       (beat),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign mem_addr  = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign m.m_valid = !fifo_empty;
    assign m.m_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign m.m_last  = !fifo_empty && fifo_head[DATA_W];

`ifdef BRAM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst)                          checksum_q <= '0;
        else if (state_q == IDLE && start) checksum_q <= '0;
        else if (beat)                    checksum_q <= checksum_q + m.m_data;
    end

    assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - self-checking bench for bram_stream_reader
module tb_bram_stream_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] base_addr = '0;
    logic [4:0] len = '0;
    logic       busy;
    logic       done;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata;
`ifdef BRAM_READER_CHECKSUM_EN
    logic [7:0] checksum;
    logic [7:0] exp_sum = '0;
    logic [7:0] sum_at_done = '0;
`endif
    logic [7:0] ram [16];

    bram_stream_reader_if #(.DATA_W(8)) s ();

    bram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
`ifdef BRAM_READER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .m         (s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_rdata <= ram[mem_addr];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the expected beat list of the current command plus observation logs.
    bit         checking = 0;
    logic [7:0] exp_q [$];
    bit         exp_busy = 0;
    bit         exp_done = 0;
    bit         stall_prev = 0;
    logic [7:0] stall_data = '0;
    logic [3:0] prev_addr = '0;
    logic [3:0] next_addr;
    int         outstanding = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         done_cyc = -1;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         beat_cyc [$];
    logic [7:0] beat_data [$];
    logic [3:0] addr_seq [$];

    always @(negedge clk) begin
        bit nxt_busy;
        bit nxt_done;
        cyc++;
        if (checking) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (exp_done) begin
                done_cyc = cyc;
`ifdef BRAM_READER_CHECKSUM_EN
                check("checksum", checksum, exp_sum);
                sum_at_done = checksum;
`endif
            end
            if (s.m_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", s.m_valid, 1'b0);
                end else begin
                    check("m_data", s.m_data, exp_q[0]);
                    check("m_last", s.m_last, exp_q.size() == 1);
                end
                if (stall_prev) check("data_held", s.m_data, stall_data);
            end else begin
                check("m_last_idle", s.m_last, 1'b0);
                if (stall_prev) check("valid_held", s.m_valid, 1'b1);
            end
            stall_prev = s.m_valid && !s.m_ready;
            stall_data = s.m_data;

            if (exp_busy) begin
                if (mem_addr != prev_addr) begin
                    next_addr = prev_addr + 4'd1;
                    check("addr_step", mem_addr, next_addr);
                    addr_seq.push_back(prev_addr);
                    outstanding++;
                end
                check("credit", outstanding <= 4, 1'b1);
            end
            prev_addr = mem_addr;

            nxt_busy = exp_busy && !exp_done;
            nxt_done = 0;
            if (s.m_valid && s.m_ready && exp_q.size() != 0) begin
                beat_data.push_back(s.m_data);
                beat_cyc.push_back(cyc);
                outstanding--;
`ifdef BRAM_READER_CHECKSUM_EN
                exp_sum = exp_sum + exp_q[0];
`endif
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) nxt_done = 1;
            end
            if (start && !exp_busy) begin
                start_cyc   = cyc;
                nxt_busy    = 1;
                outstanding = 0;
`ifdef BRAM_READER_CHECKSUM_EN
                exp_sum = '0;
`endif
                for (int i = 0; i < int'(len); i++) exp_q.push_back(ram[4'(int'(base_addr) + i)]);
                if (len == 0) nxt_done = 1;
                else          prev_addr = base_addr;
            end
            if (rst) begin
                exp_q.delete();
                nxt_busy   = 0;
                nxt_done   = 0;
                stall_prev = 0;
            end
            exp_busy = nxt_busy;
            exp_done = nxt_done;
        end
    end

    task automatic clear_log();
        beat_cyc.delete();
        beat_data.delete();
        addr_seq.delete();
        done_cyc = -1;
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic cmd(input logic [3:0] b, input logic [4:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_to_idle(input bit toggle, input int budget);
        int k = 0;
        bit [15:0] pat = 16'b1001_0110_1100_1001;
        while (exp_busy && k < budget) begin
            if (toggle) s.m_ready = pat[k % 16];
            @(posedge clk);
            #1;
            k++;
        end
        s.m_ready = 1'b1;
        check("cmd_timeout", k < budget, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic [7:0] wrap_data [4];
        logic [3:0] wrap_addr [4];
        for (int i = 0; i < 16; i++) ram[i] = 8'(i + 16);
        s.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_m_valid", s.m_valid, 1'b0);
        check("rst_m_last", s.m_last, 1'b0);
        check("rst_mem_addr", mem_addr, 4'd0);
        check("rst_m_data", s.m_data, 8'd0);
        rst = 1'b0;
        checking = 1;

        // base 2, len 5, ready held high
        clear_log();
        cmd(4'd2, 5'd5);
        run_to_idle(0, 100);
        check("t1_beats", beat_data.size(), 5);
        if (beat_data.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t1_data", beat_data[i], 8'(8'h12 + i));
            check("t1_first_latency", beat_cyc[0] - start_cyc, 3);
            check("t1_no_bubbles", beat_cyc[4] - beat_cyc[0], 4);
            check("t1_done_after_last", done_cyc - beat_cyc[4], 1);
        end

        // address wrap
        clear_log();
        wrap_data = '{8'h1E, 8'h1F, 8'h10, 8'h11};
        wrap_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
        cmd(4'd14, 5'd4);
        run_to_idle(0, 100);
        check("t2_beats", beat_data.size(), 4);
        check("t2_issues", addr_seq.size(), 4);
        if (beat_data.size() == 4 && addr_seq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_data", beat_data[i], wrap_data[i]);
                check("t2_addr", addr_seq[i], wrap_addr[i]);
            end
        end

        // full window under backpressure, with a start that must be ignored
        clear_log();
        cmd(4'd0, 5'd16);
        s.m_ready = 1'b0;
        cmd(4'd5, 5'd3);
        run_to_idle(1, 400);
        check("t3_beats", beat_data.size(), 16);
        if (beat_data.size() == 16) begin
            for (int i = 0; i < 16; i++) check("t3_data", beat_data[i], 8'(8'h10 + i));
        end
        check("t3_done_pulses", done_cnt, 1);
`ifdef BRAM_READER_CHECKSUM_EN
        check("t3_checksum", sum_at_done, 8'h78);
`endif

        // zero-length command
        clear_log();
        cmd(4'd3, 5'd0);
        run_to_idle(0, 20);
        check("t4_beats", beat_data.size(), 0);
        check("t4_busy_cycles", busy_cnt, 1);
        check("t4_done_latency", done_cyc - start_cyc, 1);

        // reset in the middle of a command
        clear_log();
        cmd(4'd0, 5'd10);
        k = 0;
        while (beat_data.size() < 3 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t5_reach_beat3", beat_data.size(), 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_valid_after_rst", s.m_valid, 1'b0);
        check("t5_busy_after_rst", busy, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("t5_no_done", done_cnt, 0);
        clear_log();
        cmd(4'd0, 5'd2);
        run_to_idle(0, 50);
        check("t5_beats", beat_data.size(), 2);
        if (beat_data.size() == 2) begin
            check("t5_data0", beat_data[0], 8'h10);
            check("t5_data1", beat_data[1], 8'h11);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
